// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared FSM state type and ALU opcodes for the shift-add multiplier
package mul_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

endpackage

// File: rtl/mul_seq_alu.sv
// rtl/mul_seq_alu.sv - N-bit execute-stage ALU reused as the multiplier's accumulate adder
module mul_seq_alu #(
   parameter int N = 64
) (
   input  logic [N-1:0] srca,
   input  logic [N-1:0] srcb,
   input  logic [3:0]   alu_control,
   output logic [N-1:0] alu_result,
   output logic         zero
);
   import mul_seq_pkg::*;

   always_comb begin
      case (alu_control)
         ALU_AND:   alu_result = srca & srcb;
         ALU_ORR:   alu_result = srca | srcb;
         ALU_ADD:   alu_result = srca + srcb;
         ALU_SUB:   alu_result = srca - srcb;
         ALU_PASSB: alu_result = srcb;
         default:   alu_result = '0;
      endcase
   end

   assign zero = (alu_result == '0);

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative shift-add multiplier, low N bits of a*b via one ALU add per cycle
module mul_seq #(
   parameter int N          = 64,
   parameter int EARLY_EXIT = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         zero
);
   import mul_seq_pkg::*;

   localparam int CW = $clog2(N) + 1;

   state_t        state;
   logic [N-1:0]  acc;
   logic [N-1:0]  mcand;
   logic [N-1:0]  mplier;
   logic [CW-1:0] cnt;
   logic [N-1:0]  sum;
   logic [N-1:0]  acc_next;
   logic          last;
   logic          unused_alu_zero;

   mul_seq_alu #(.N(N)) u_alu (
      .srca        (acc),
      .srcb        (mcand),
      .alu_control (ALU_ADD),
      .alu_result  (sum),
      .zero        (unused_alu_zero)
   );

   // last is evaluated on the pre-shift multiplier, so this cycle's add is included
   always_comb begin
      acc_next = mplier[0] ? sum : acc;
      last     = (cnt == CW'(N - 1)) ||
                 ((EARLY_EXIT != 0) && ((mplier >> 1) == '0));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         zero   <= 1'b1;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= a;
                  mplier <= b;
                  acc    <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  result <= acc_next;
                  zero   <= (acc_next == '0);
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed self-checking bench for mul_seq with a cycle-level behavioural model
module tb_mul_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_v [2];
   logic [63:0] a_v [2];
   logic [63:0] b_v [2];

   logic        busy0, done0, zero0, busy1, done1, zero1;
   logic [63:0] res0, res1;

   int nvec = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   mul_seq #(.N(64), .EARLY_EXIT(1)) dut_ee (
      .clk(clk), .reset(reset), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
      .busy(busy0), .done(done0), .result(res0), .zero(zero0)
   );

   mul_seq #(.N(64), .EARLY_EXIT(0)) dut_full (
      .clk(clk), .reset(reset), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
      .busy(busy1), .done(done1), .result(res1), .zero(zero1)
   );

   always #5 clk = ~clk;

   // model: product is a*b mod 2^64, run length k from the multiplier's top set bit
   bit          m_busy [2];
   bit          m_done [2];
   bit          m_zero [2];
   logic [63:0] m_res  [2];
   logic [63:0] m_pend [2];
   int          m_left [2];

   function automatic int kcalc(bit ee, logic [63:0] bb);
      if (!ee) return 64;
      for (int j = 63; j >= 0; j--)
         if (bb[j]) return j + 1;
      return 1;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_busy[i] = 1'b0; m_done[i] = 1'b0; m_res[i] = '0; m_zero[i] = 1'b1; m_left[i] = 0;
         end else if (m_done[i]) begin
            m_done[i] = 1'b0; m_busy[i] = 1'b0;
         end else if (m_busy[i]) begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin
               m_done[i] = 1'b1;
               m_res[i]  = m_pend[i];
               m_zero[i] = (m_pend[i] == 64'd0);
            end
         end else if (start_v[i]) begin
            m_busy[i] = 1'b1;
            m_left[i] = kcalc(i == 0, b_v[i]);
            m_pend[i] = a_v[i] * b_v[i];
         end
      end
   end

   task automatic cmp(int i, logic bz, logic dn, logic [63:0] r, logic z);
      nvec++;
      if (bz !== m_busy[i] || dn !== m_done[i] || r !== m_res[i] || z !== m_zero[i]) begin
         nerr++;
         $display("FAIL model inst%0d t=%0t: busy/done/result/zero got %b/%b/%h/%b want %b/%b/%h/%b",
                  i, $time, bz, dn, r, z, m_busy[i], m_done[i], m_res[i], m_zero[i]);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp(0, busy0, done0, res0, zero0);
         cmp(1, busy1, done1, res1, zero1);
      end
   end

   task automatic lit(string nm, logic [63:0] act, logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic get_done(int i);
      return (i == 0) ? done0 : done1;
   endfunction

   function automatic logic get_busy(int i);
      return (i == 0) ? busy0 : busy1;
   endfunction

   function automatic logic [63:0] get_res(int i);
      return (i == 0) ? res0 : res1;
   endfunction

   function automatic logic get_zero(int i);
      return (i == 0) ? zero0 : zero1;
   endfunction

   // n counts cycles after the accepting edge; done must appear at n == k+1
   task automatic run_op(int i, logic [63:0] aa, logic [63:0] bb, logic [63:0] exp_r,
                         int exp_k, int poke, string nm);
      int n;
      start_v[i] = 1'b1; a_v[i] = aa; b_v[i] = bb;
      @(negedge clk);
      start_v[i] = 1'b0;
      n = 1;
      while (!get_done(i) && n < 200) begin
         lit({nm, "_busy"}, 64'(get_busy(i)), 64'd1);
         @(negedge clk);
         n++;
         if (n == poke) begin
            start_v[i] = 1'b1; a_v[i] = 64'd9; b_v[i] = 64'd9;
         end else begin
            start_v[i] = 1'b0;
         end
      end
      lit({nm, "_latency"}, 64'(n), 64'(exp_k + 1));
      lit({nm, "_result"}, get_res(i), exp_r);
      lit({nm, "_zero"}, 64'(get_zero(i)), 64'(exp_r == 64'd0));
      @(negedge clk);
      lit({nm, "_idle"}, 64'(get_busy(i)), 64'd0);
   endtask

   initial begin
      int ndone;
      logic [63:0] dstamp;

      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
      end
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      lit("reset_busy", 64'(busy0), 64'd0);
      lit("reset_done", 64'(done0), 64'd0);
      lit("reset_result", res0, 64'd0);
      lit("reset_zero", 64'(zero0), 64'd1);
      reset = 1'b0;
      @(negedge clk);

      run_op(0, 64'd3, 64'd5, 64'd15, 3, 0, "basic");
      run_op(0, 64'h1234, 64'd0, 64'd0, 1, 0, "zero_mplier");
      run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2, 0, "wrap");
      run_op(0, 64'd1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 64, 0, "worst");
      run_op(1, 64'd3, 64'd5, 64'd15, 64, 0, "no_early_exit");
      run_op(0, 64'd3, 64'd5, 64'd15, 3, 2, "start_in_run");

      // start held high: accepts 4 edges apart, dones on cycles 3, 7 and 11
      ndone = 0;
      dstamp = '0;
      start_v[0] = 1'b1; a_v[0] = 64'd2; b_v[0] = 64'd3;
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         if (done0) begin
            ndone++;
            dstamp = (dstamp << 4) | 64'(n);
            lit("b2b_result", res0, 64'd6);
         end
         if (n == 11) start_v[0] = 1'b0;
      end
      lit("b2b_done_count", 64'(ndone), 64'd3);
      lit("b2b_done_cycles", dstamp, 64'h37B);
      @(negedge clk);

      // reset during the 10th RUN cycle of a 64-cycle run
      start_v[0] = 1'b1; a_v[0] = 64'd1; b_v[0] = 64'h8000_0000_0000_0001;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (9) @(negedge clk);
      lit("midrun_busy", 64'(busy0), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      lit("midrun_rst_busy", 64'(busy0), 64'd0);
      lit("midrun_rst_done", 64'(done0), 64'd0);
      lit("midrun_rst_result", res0, 64'd0);
      lit("midrun_rst_zero", 64'(zero0), 64'd1);
      ndone = 0;
      repeat (70) begin
         @(negedge clk);
         if (done0) ndone++;
      end
      lit("midrun_no_done", 64'(ndone), 64'd0);
      run_op(0, 64'd7, 64'd6, 64'd42, 3, 0, "after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
